quad_encoder_if: RTL and testbench
==================================

# quad_encoder_if

Quadrature encoder front end for the BLDC controller: synchronises and optionally filters the motor's `encoder_a`/`encoder_b` pins, decodes them at 4x resolution, and keeps a wrapping position count and a windowed signed velocity. It sits directly upstream of the control/I2C register stage, which reads `position`, `velocity` and `illegal_err`. That stage also drives `pos_clear` and `err_clear`.

## Interface
- `POS_W`, 16: position counter width.
- `VEL_W`, 12: signed velocity width.
- `WINDOW_CYCLES`, 50000: velocity measurement window in clk cycles (≥2).
- `FILT_LEN`, 3: samples a level must hold before it is accepted (used only with the filter compiled in, ≥2).
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `encoder_a` in 1: raw channel A (asynchronous).
- `encoder_b` in 1: raw channel B (asynchronous).
- `pos_clear` in 1: single-cycle pulse that zeroes `position`.
- `err_clear` in 1: single-cycle pulse that clears `illegal_err`.
- `position` out POS_W: unsigned 4x count, wraps modulo 2^POS_W.
- `velocity` out VEL_W: signed net counts in the last completed window.
- `vel_valid` out 1: one-cycle pulse when `velocity` updates.
- `dir` out 1: direction of the last valid step (1 = forward, A leads B).
- `step_pulse` out 1: one-cycle pulse per valid decoded step.
- `illegal_err` out 1: sticky flag for a double-bit transition.

## Operation
- **Synchronisation**
  - Each pin goes through a 2-flop synchroniser.
  - Synchroniser flops reset to 0.
- **Decode**
  - The filtered AB pair is compared against the previous AB each cycle.
  - Forward sequence: 00→01→11→10→00. Forward gives +1 and `dir`=1.
  - Reverse sequence gives −1 and `dir`=0.
  - No change: nothing happens.
  - Both bits changed: illegal. Position and velocity are unchanged, `dir` holds, and `illegal_err` is set.
- **Init**
  - An `init` flag is set on reset.
  - The first cycle after reset loads previous-AB from the current filtered AB, without counting or flagging, then clears `init`.
- **Position**
  - +1/−1 arithmetic modulo 2^POS_W; 0 − 1 = 2^POS_W − 1.
  - `pos_clear` has priority: a step in the same cycle is dropped from `position`, giving 0.
  - That dropped step still reaches the velocity accumulator, `step_pulse` and `dir`.
- **Velocity**
  - A window counter runs 0..WINDOW_CYCLES−1.
  - A signed accumulator (VEL_W+1 bits internal) sums the steps.
  - On the last window cycle, `velocity` is loaded with the accumulator plus that cycle's step, saturated to ±(2^(VEL_W−1)−1), and `vel_valid` pulses.
  - The accumulator restarts at 0 in the next cycle. The window is free-running and is not affected by `pos_clear`.
- **Error**
  - `illegal_err` is set if a new illegal transition arrives in the same cycle as `err_clear` (set wins); otherwise `err_clear` clears it.

## Timing
- **Reset values:** `position`=0, `velocity`=0, `vel_valid`=0, `dir`=0, `step_pulse`=0, `illegal_err`=0. The window counter and accumulator are 0 and `init` is 1.
- **Latency:** from pin edge to `position`/`step_pulse` is 3 cycles without the filter: 2 sync + 1 decode register.
- With the filter, add FILT_LEN cycles.
- All outputs are registered.
- **Reset mid-operation** clears everything asynchronously. The first sample after release only loads previous-AB.
- **Max input rate:** one transition per FILT_LEN+1 cycles with the filter, or per 2 cycles without it. Faster input is reported as illegal, never miscounted silently.

## Configuration
- `QENC_FILTER_EN` defined:
  - Each synchronised channel passes through a FILT_LEN-sample stability filter.
  - The filtered output changes only after FILT_LEN consecutive equal samples that differ from it.
  - Shorter glitches are discarded.
- `QENC_FILTER_EN` undefined: the synchroniser outputs feed the decoder directly, and `FILT_LEN` is ignored.

## Structure
- **`qenc_pkg`:** step encoding constant (+1, −1, 0, illegal) and the `qenc_step_t` enum.
- **Decode function:** in `qenc_pkg`, maps {prev_ab, cur_ab} to `qenc_step_t`.
- **`qenc_glitch_filter` sub-module:**
  - Per-channel, parameter FILT_LEN, ports clk/rst_n/d/q; q resets to 0.
  - Instantiated twice, only under `QENC_FILTER_EN`.

## Test plan
- **Forward rotation:** reset, then 8 forward quadrature steps spaced 10 cycles apart → `position`=8, 8 `step_pulse`s, `dir`=1, `illegal_err`=0.
- **Reverse wrap:** from `position`=0, 3 reverse steps → `position`=0xFFFD (POS_W=16), `dir`=0.
- **Velocity:** WINDOW_CYCLES=100, 5 forward steps in one window → `vel_valid` at cycle 100 with `velocity`=5. The next empty window → `velocity`=0.
- **Illegal transition:** AB 00→11 → `position` unchanged and `illegal_err`=1. `err_clear` → 0. `err_clear` in the same cycle as another 00→11 → stays 1.
- **Clear priority:** `pos_clear` in the same cycle as a forward step → `position`=0, `step_pulse`=1, window accumulator +1.
- **Glitch (filter on, FILT_LEN=3):** a 2-cycle pulse on A → no step. A held 3 cycles → one step, with `step_pulse` at 6 cycles after the pin edge. Filter off: a 2-cycle pulse gives +1 then −1.

Source files
------------

// File: rtl/qenc_pkg.sv
// qenc_pkg: step encoding shared by the quadrature decoder, plus the
// {prev, cur} -> step decode function. AB pairs are packed {B, A}.
package qenc_pkg;

   typedef enum logic [1:0] {
      STEP_NONE = 2'b00,
      STEP_FWD  = 2'b01,
      STEP_REV  = 2'b10,
      STEP_ILL  = 2'b11
   } qenc_step_t;

   // Forward order 00 -> 01 -> 11 -> 10 -> 00 with pairs read as {B, A}, so A leads B.
   function automatic qenc_step_t qenc_decode(input logic [1:0] prev_ab,
                                              input logic [1:0] cur_ab);
      qenc_step_t step;
      step = STEP_NONE;
      if ((prev_ab ^ cur_ab) == 2'b11) begin
         step = STEP_ILL;
      end else if (prev_ab != cur_ab) begin
         case ({prev_ab, cur_ab})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step = STEP_FWD;
            default:                                 step = STEP_REV;
         endcase
      end
      return step;
   endfunction

endpackage

// File: rtl/qenc_glitch_filter.sv
// qenc_glitch_filter: per-channel stability filter; q follows d only after
// FILT_LEN consecutive samples that differ from the current q.
module qenc_glitch_filter #(
   parameter int unsigned FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   localparam int unsigned CNT_W = $clog2(FILT_LEN);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_q, q_d;

   always_comb begin
      cnt_d = '0;
      q_d   = q_q;
      if (d != q_q) begin
         if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
            q_d = d;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         q_q   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         q_q   <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/quad_encoder_if.sv
// quad_encoder_if: encoder pin synchronisation, 4x decode, wrapping position
// and windowed saturating velocity. Define QENC_FILTER_EN to add glitch filters.
module quad_encoder_if
   import qenc_pkg::*;
#(
   parameter int unsigned POS_W         = 16,
   parameter int unsigned VEL_W         = 12,
   parameter int unsigned WINDOW_CYCLES = 50000,
   parameter int unsigned FILT_LEN      = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             encoder_a,
   input  logic             encoder_b,
   input  logic             pos_clear,
   input  logic             err_clear,
   output logic [POS_W-1:0] position,
   output logic [VEL_W-1:0] velocity,
   output logic             vel_valid,
   output logic             dir,
   output logic             step_pulse,
   output logic             illegal_err
);

   localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES);

   localparam logic signed [VEL_W+1:0] ACC_MAX = {2'b00, {VEL_W{1'b1}}};
   localparam logic signed [VEL_W+1:0] ACC_MIN = -ACC_MAX - 1;
   localparam logic signed [VEL_W+1:0] VEL_MAX = {3'b000, {(VEL_W-1){1'b1}}};
   localparam logic signed [VEL_W+1:0] VEL_MIN = -VEL_MAX;

   if (WINDOW_CYCLES < 2 || FILT_LEN < 2) begin : g_bad_params
      $error("quad_encoder_if: WINDOW_CYCLES and FILT_LEN must be >= 2");
   end

   logic [1:0]              a_sync_q, b_sync_q;
   logic                    a_filt, b_filt;
   logic [1:0]              cur_ab, prev_ab_q, prev_ab_d;
   logic                    init_q, init_d;
   qenc_step_t              step;
   logic signed [VEL_W+1:0] step_val, acc_sum;
   logic [POS_W-1:0]        pos_q, pos_d;
   logic [VEL_W-1:0]        vel_q, vel_d;
   logic                    vel_valid_q, vel_valid_d;
   logic                    dir_q, dir_d;
   logic                    step_pulse_q, step_pulse_d;
   logic                    err_q, err_d;
   logic [WIN_W-1:0]        win_q, win_d;
   logic signed [VEL_W:0]   acc_q, acc_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sync_q <= '0;
         b_sync_q <= '0;
      end else begin
         a_sync_q <= {a_sync_q[0], encoder_a};
         b_sync_q <= {b_sync_q[0], encoder_b};
      end
   end

`ifdef QENC_FILTER_EN
   qenc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
      .clk(clk), .rst_n(rst_n), .d(a_sync_q[1]), .q(a_filt)
   );
   qenc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
      .clk(clk), .rst_n(rst_n), .d(b_sync_q[1]), .q(b_filt)
   );
`else
   assign a_filt = a_sync_q[1];
   assign b_filt = b_sync_q[1];
`endif

   assign cur_ab = {b_filt, a_filt};

   always_comb begin
      prev_ab_d    = cur_ab;
      init_d       = 1'b0;
      step         = init_q ? STEP_NONE : qenc_decode(prev_ab_q, cur_ab);
      step_val     = '0;
      pos_d        = pos_q;
      dir_d        = dir_q;
      step_pulse_d = 1'b0;
      err_d        = err_q;
      vel_d        = vel_q;
      vel_valid_d  = 1'b0;
      win_d        = win_q + 1'b1;
      acc_d        = acc_q;

      case (step)
         STEP_FWD: begin
            step_val     = (VEL_W+2)'(1);
            pos_d        = pos_q + 1'b1;
            dir_d        = 1'b1;
            step_pulse_d = 1'b1;
         end
         STEP_REV: begin
            step_val     = '1;
            pos_d        = pos_q - 1'b1;
            dir_d        = 1'b0;
            step_pulse_d = 1'b1;
         end
         default: ;
      endcase

      // Clear drops the step from position only; velocity, dir and pulse still see it.
      if (pos_clear) pos_d = '0;

      if (step == STEP_ILL)  err_d = 1'b1;
      else if (err_clear)    err_d = 1'b0;

      acc_sum = {acc_q[VEL_W], acc_q} + step_val;

      if (win_q == WIN_W'(WINDOW_CYCLES - 1)) begin
         win_d       = '0;
         acc_d       = '0;
         vel_valid_d = 1'b1;
         if (acc_sum > VEL_MAX)      vel_d = VEL_MAX[VEL_W-1:0];
         else if (acc_sum < VEL_MIN) vel_d = VEL_MIN[VEL_W-1:0];
         else                        vel_d = acc_sum[VEL_W-1:0];
      end else begin
         // Clamp so long windows at full input rate cannot wrap the accumulator.
         if (acc_sum > ACC_MAX)      acc_d = ACC_MAX[VEL_W:0];
         else if (acc_sum < ACC_MIN) acc_d = ACC_MIN[VEL_W:0];
         else                        acc_d = acc_sum[VEL_W:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_ab_q    <= '0;
         init_q       <= 1'b1;
         pos_q        <= '0;
         vel_q        <= '0;
         vel_valid_q  <= 1'b0;
         dir_q        <= 1'b0;
         step_pulse_q <= 1'b0;
         err_q        <= 1'b0;
         win_q        <= '0;
         acc_q        <= '0;
      end else begin
         prev_ab_q    <= prev_ab_d;
         init_q       <= init_d;
         pos_q        <= pos_d;
         vel_q        <= vel_d;
         vel_valid_q  <= vel_valid_d;
         dir_q        <= dir_d;
         step_pulse_q <= step_pulse_d;
         err_q        <= err_d;
         win_q        <= win_d;
         acc_q        <= acc_d;
      end
   end

   assign position    = pos_q;
   assign velocity    = vel_q;
   assign vel_valid   = vel_valid_q;
   assign dir         = dir_q;
   assign step_pulse  = step_pulse_q;
   assign illegal_err = err_q;

endmodule

// File: tb/tb_quad_encoder_if.sv
// tb_quad_encoder_if: scoreboard bench; stimulus pushes expected steps and
// per-window sums, a negedge monitor checks step_pulse and vel_valid events.
module tb_quad_encoder_if;

   localparam int unsigned POS_W    = 16;
   localparam int unsigned VEL_W    = 5;
   localparam int unsigned WIN      = 100;
   localparam int unsigned FILT_LEN = 3;
`ifdef QENC_FILTER_EN
   localparam int LAT     = 3 + FILT_LEN;
   localparam int GAP_MIN = FILT_LEN + 1;
`else
   localparam int LAT     = 3;
   localparam int GAP_MIN = 2;
`endif
   localparam int VMAX     = (1 << (VEL_W - 1)) - 1;
   localparam int POS_MASK = (1 << POS_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             encoder_a = 1'b0;
   logic             encoder_b = 1'b0;
   logic             pos_clear = 1'b0;
   logic             err_clear = 1'b0;
   logic [POS_W-1:0] position;
   logic [VEL_W-1:0] velocity;
   logic             vel_valid, dir, step_pulse, illegal_err;

   quad_encoder_if #(
      .POS_W(POS_W), .VEL_W(VEL_W), .WINDOW_CYCLES(WIN), .FILT_LEN(FILT_LEN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .encoder_a(encoder_a), .encoder_b(encoder_b),
      .pos_clear(pos_clear), .err_clear(err_clear), .position(position),
      .velocity(velocity), .vel_valid(vel_valid), .dir(dir),
      .step_pulse(step_pulse), .illegal_err(illegal_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int edge_n;
      int pos;
      int fwd;
   } step_exp_t;

   step_exp_t exp_q[$];
   int        win_sum[int];
   int        cyc;
   int        vectors = 0;
   int        miscompares = 0;
   int        steps_seen = 0;
   int        model_ab = 0;    // {B, A}
   int        model_pos = 0;
   int        model_dir = 0;
   int        seq[4] = '{0, 1, 3, 2};
   step_exp_t mon_e;
   int        mon_k;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, actual, expected);
      end
   endtask

   function automatic int sat(input int v);
      if (v > VMAX)  return VMAX;
      if (v < -VMAX) return -VMAX;
      return v;
   endfunction

   function automatic int idx_of(input int ab);
      for (int i = 0; i < 4; i++) if (seq[i] == ab) return i;
      return 0;
   endfunction

   // Monitor: pops the scoreboard on every DUT step and checks window results.
   always @(negedge clk) begin
      if (rst_n) begin
         if (step_pulse) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL step_pulse at cycle %0d: got unexpected pulse, want none", cyc);
            end else begin
               mon_e = exp_q.pop_front();
               steps_seen++;
               check("step_cycle", cyc, mon_e.edge_n);
               check("step_position", 32'(position), mon_e.pos);
               check("step_dir", 32'(dir), mon_e.fwd);
            end
         end
         while (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
            mon_e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL step_missing at cycle %0d: got no pulse, want one at cycle %0d", cyc, mon_e.edge_n);
         end
         if (cyc > 0 && (vel_valid || (cyc % WIN) == 0)) begin
            check("vel_valid", 32'(vel_valid), ((cyc % WIN) == 0) ? 1 : 0);
            if ((cyc % WIN) == 0) begin
               mon_k = (cyc - 1) / WIN;
               check("velocity", 32'($signed(velocity)),
                     sat(win_sum.exists(mon_k) ? win_sum[mon_k] : 0));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_ab(input int ab);
      encoder_a = ab[0];
      encoder_b = ab[1];
   endtask

   task automatic move(input int fwd, input int with_clear);
      int idx, nab, n, w, d;
      idx = idx_of(model_ab);
      nab = fwd ? seq[(idx + 1) % 4] : seq[(idx + 3) % 4];
      d   = fwd ? 1 : -1;
      n   = cyc + LAT;
      w   = (n - 1) / WIN;
      model_pos = with_clear ? 0 : ((model_pos + d) & POS_MASK);
      model_dir = fwd;
      if (!win_sum.exists(w)) win_sum[w] = 0;
      win_sum[w] += d;
      exp_q.push_back('{n, model_pos, fwd});
      model_ab = nab;
      drive_ab(nab);
   endtask

   task automatic step_with_clear(input int fwd);
      move(fwd, 1);
      tick(LAT - 1);
      pos_clear = 1'b1;
      tick(1);
      pos_clear = 1'b0;
   endtask

   task automatic illegal_move(input int with_clear);
      model_ab = model_ab ^ 3;
      drive_ab(model_ab);
      if (with_clear) begin
         tick(LAT - 1);
         err_clear = 1'b1;
         tick(1);
         err_clear = 1'b0;
         tick(2);
      end else begin
         tick(LAT + 2);
      end
      check("illegal_err_set", 32'(illegal_err), 1);
      check("illegal_position", 32'(position), model_pos);
      check("illegal_dir_hold", 32'(dir), model_dir);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_position"}, 32'(position), 0);
      check({tag, "_velocity"}, 32'(velocity), 0);
      check({tag, "_vel_valid"}, 32'(vel_valid), 0);
      check({tag, "_dir"}, 32'(dir), 0);
      check({tag, "_step_pulse"}, 32'(step_pulse), 0);
      check({tag, "_illegal_err"}, 32'(illegal_err), 0);
   endtask

   task automatic do_reset(input int async_check);
      rst_n = 1'b0;
      #1;
      if (async_check) check_reset_outputs("async_rst");
      drive_ab(0);
      model_ab  = 0;
      model_pos = 0;
      model_dir = 0;
      exp_q.delete();
      win_sum.delete();
      tick(2);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      tick(3);
   endtask

   task automatic align_window();
      for (int i = 0; i < int'(WIN); i++) begin
         if ((cyc % WIN) == 0) break;
         tick(1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, want $finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int gap, n_burst;

      do_reset(0);

      // Forward rotation: 8 steps, 10 cycles apart.
      for (int i = 0; i < 8; i++) begin
         move(1, 0);
         tick(10);
      end
      tick(LAT + 2);
      check("fwd_position", 32'(position), 8);
      check("fwd_steps_seen", steps_seen, 8);
      check("fwd_dir", 32'(dir), 1);
      check("fwd_illegal_err", 32'(illegal_err), 0);

      // Standalone clear, then reverse through zero.
      pos_clear = 1'b1;
      tick(1);
      pos_clear = 1'b0;
      model_pos = 0;
      tick(1);
      check("clear_position", 32'(position), 0);
      for (int i = 0; i < 3; i++) begin
         move(0, 0);
         tick(10);
      end
      tick(LAT + 2);
      check("rev_wrap_position", 32'(position), 32'h0000_FFFD);
      check("rev_dir", 32'(dir), 0);

      // Velocity: 5 forward steps inside one window, then an empty window.
      align_window();
      for (int i = 0; i < 5; i++) begin
         move(1, 0);
         tick(10);
      end
      tick(2 * WIN);

      // Illegal transitions and error-clear priority.
      illegal_move(0);
      err_clear = 1'b1;
      tick(1);
      err_clear = 1'b0;
      check("err_clear", 32'(illegal_err), 0);
      illegal_move(0);
      illegal_move(1);

      // Clear coinciding with a forward step.
      tick(10);
      step_with_clear(1);
      tick(2);
      check("clear_prio_position", 32'(position), 0);
      check("clear_prio_dir", 32'(dir), 1);

      // Short pulse on A.
      tick(10);
`ifdef QENC_FILTER_EN
      encoder_a = ~encoder_a;
      tick(2);
      encoder_a = ~encoder_a;
      tick(LAT + 4);
      check("glitch_position", 32'(position), model_pos);
      move(1, 0);
      tick(LAT + 4);
`else
      move(1, 0);
      tick(2);
      move(0, 0);
      tick(LAT + 4);
`endif
      check("glitch_position", 32'(position), model_pos);

      // Saturating bursts in both directions, each inside one window.
      n_burst = (int'(WIN) - 10) / GAP_MIN;
      align_window();
      for (int i = 0; i < n_burst; i++) begin
         move(1, 0);
         tick(GAP_MIN);
      end
      align_window();
      for (int i = 0; i < n_burst; i++) begin
         move(0, 0);
         tick(GAP_MIN);
      end
      tick(WIN + 2);

      // Random legal walk with occasional coincident clears.
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            step_with_clear(int'($urandom_range(0, 1)));
         end else begin
            gap = int'($urandom_range(GAP_MIN, GAP_MIN + 4));
            move(int'($urandom_range(0, 1)), 0);
            tick(gap);
         end
      end
      tick(LAT + 2);
      check("random_position", 32'(position), model_pos);

      // Reset in the middle of activity, then resume.
      move(1, 0);
      tick(GAP_MIN);
      move(1, 0);
      tick(1);
      do_reset(1);
      for (int i = 0; i < 4; i++) begin
         move(0, 0);
         tick(GAP_MIN + 1);
      end
      tick(LAT + 2);
      check("post_reset_position", 32'(position), 32'h0000_FFFC);
      tick(WIN);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
